// File: rtl/signed_integrate_dump.sv
// signed_integrate_dump
// Integrate-and-dump accumulator for signed samples. Sums NSAMP accepted
// samples into a full-precision result, presents it with a valid/ready
// handshake, and holds it until downstream takes it. While a result is
// waiting, upstream is throttled to the downstream ready so that the first
// sample of the next block can enter in the same cycle as the consume.

module signed_integrate_dump #(
    parameter  int IWIDTH = 17,
    parameter  int NSAMP  = 8,
    localparam int OWIDTH = IWIDTH + $clog2(NSAMP),
    localparam int CWIDTH = $clog2(NSAMP)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [IWIDTH-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OWIDTH-1:0] o_data,
    output logic [CWIDTH-1:0] o_count
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CWIDTH-1:0] LAST_COUNT = CWIDTH'(NSAMP - 1);

    state_t                    state_r;
    state_t                    state_next_s;
    logic signed [OWIDTH-1:0]  acc_r;
    logic signed [OWIDTH-1:0]  data_r;
    logic [CWIDTH-1:0]         count_r;
    logic                      valid_r;
    logic                      ready_s;
    logic                      accept_s;
    logic                      consume_s;
    logic                      last_s;
    logic signed [OWIDTH-1:0]  sample_ext_s;

    // Widen a two's-complement sample to the accumulator width.
    function automatic logic signed [OWIDTH-1:0] sign_extend(input logic [IWIDTH-1:0] x);
        return {{(OWIDTH - IWIDTH){x[IWIDTH-1]}}, x};
    endfunction

    assign accept_s     = i_valid && ready_s;
    assign consume_s    = valid_r && i_ready;
    assign last_s       = (count_r == LAST_COUNT);
    assign sample_ext_s = sign_extend(i_data);

    assign o_ready = ready_s;
    assign o_valid = valid_r;
    assign o_data  = data_r;
    assign o_count = count_r;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; clear always returns to accumulation.
    always_comb begin
        state_next_s = state_r;
        if (i_clear) begin
            state_next_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s && last_s) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (consume_s) begin
                        state_next_s = ST_ACCUM;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                default: begin
                    state_next_s = ST_ACCUM;
                end
            endcase
        end
    end

    // Upstream ready: free-running while accumulating, tied to downstream while holding.
    always_comb begin
        ready_s = 1'b1;
        case (state_r)
            ST_ACCUM: ready_s = 1'b1;
            ST_HOLD:  ready_s = i_ready;
            default:  ready_s = 1'b1;
        endcase
    end

    // Accumulator, sample counter and result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r   <= '0;
            count_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (i_clear) begin
            acc_r   <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s && last_s) begin
                        data_r  <= acc_r + sample_ext_s;
                        acc_r   <= '0;
                        count_r <= '0;
                        valid_r <= 1'b1;
                    end else if (accept_s) begin
                        acc_r   <= acc_r + sample_ext_s;
                        count_r <= count_r + CWIDTH'(1);
                    end else begin
                        acc_r   <= acc_r;
                        count_r <= count_r;
                    end
                end
                ST_HOLD: begin
                    if (consume_s) begin
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                    // A sample accepted alongside the consume opens the next block.
                    if (accept_s) begin
                        acc_r   <= sample_ext_s;
                        count_r <= CWIDTH'(1);
                    end else begin
                        acc_r   <= acc_r;
                        count_r <= count_r;
                    end
                end
                default: begin
                    acc_r   <= '0;
                    count_r <= '0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/signed_integrate_dump.md
SIGNED_INTEGRATE_DUMP -- requirements
Module: signed_integrate_dump

Interface
REQ-001 SHALL have parameter IWIDTH, default 17, the signed input sample width (matches a 16+16 signed adder sum).
REQ-002 SHALL have parameter NSAMP, default 8, the samples per dump block; legal range 2..1024.
REQ-003 SHALL derive localparam OWIDTH = IWIDTH + $clog2(NSAMP) and localparam CWIDTH = $clog2(NSAMP).
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_clear, input, 1, synchronous block restart.
REQ-007 SHALL have port i_valid, input, 1, the upstream sample valid.
REQ-008 SHALL have port o_ready, output, 1, indicating this block accepts a sample this cycle.
REQ-009 SHALL have port i_data, input, IWIDTH, the signed two's-complement sample.
REQ-010 SHALL have port o_valid, output, 1, indicating the dump result is valid.
REQ-011 SHALL have port i_ready, input, 1, the downstream accept.
REQ-012 SHALL have port o_data, output, OWIDTH, the signed block sum.
REQ-013 SHALL have port o_count, output, CWIDTH, the samples accumulated in the current block.

Function
REQ-014 SHALL treat a sample as accepted when i_valid && o_ready at a rising edge, and a result as consumed when o_valid && i_ready.
REQ-015 SHALL implement two states, ACCUM and HOLD.
REQ-016 SHALL drive o_ready = 1 in ACCUM and o_ready = i_ready in HOLD, combinationally.
REQ-017 SHALL sign-extend each accepted i_data to OWIDTH before adding; no saturation, since OWIDTH cannot overflow for NSAMP samples.
REQ-018 SHALL, in ACCUM, on an accepted sample with o_count < NSAMP-1, register acc <= acc + sample and o_count <= o_count + 1.
REQ-019 SHALL, in ACCUM, on an accepted sample with o_count == NSAMP-1, register o_data <= acc + sample, acc <= 0, o_count <= 0, o_valid <= 1, and move to HOLD.
REQ-020 SHALL therefore assert o_valid exactly one cycle after the NSAMP-th accepted sample.
REQ-021 SHALL hold o_data and o_valid stable in HOLD while i_ready is 0.
REQ-022 SHALL, in HOLD on consume, clear o_valid next cycle and return to ACCUM.
REQ-023 SHALL, when a sample is accepted in the same HOLD cycle as a consume, treat it as the first sample of the next block: acc <= sample, o_count <= 1.
REQ-024 SHALL leave acc, o_count and o_data unchanged in cycles with no accepted sample.
REQ-025 SHALL give i_clear priority over all other events: next cycle acc = 0, o_count = 0, o_valid = 0, state = ACCUM; any sample presented with i_clear is dropped; any pending result is discarded.
REQ-026 SHALL hold o_data at its last dumped value after consume or clear; o_data is meaningful only while o_valid = 1.
REQ-027 SHALL accept samples with o_count values 0..NSAMP-1 only; o_count never reaches NSAMP.

Reset
REQ-028 SHALL, on i_rst_n = 0 and independent of i_clk, force state = ACCUM, acc = 0, o_count = 0, o_valid = 0 and o_data = 0.
REQ-029 SHALL drive o_ready = 1 during and after reset.
REQ-030 SHALL discard a partially accumulated block when reset is asserted mid-block; the first accepted sample after deassertion starts a new block.
REQ-031 SHALL resume normal operation on the first rising edge after i_rst_n deasserts.

Verification
REQ-032 SHALL cover a basic dump (NSAMP=4, IWIDTH=17): samples 10, -15, 100, -3 on consecutive cycles with i_ready=1 -> o_valid high one cycle after the 4th sample, o_data = 92, o_count = 0.
REQ-033 SHALL cover extremes: four samples of +65535 -> o_data = 262140; four samples of -65536 -> o_data = -262144 (19-bit minimum), with no wrap.
REQ-034 SHALL cover backpressure: i_ready=0 for 5 cycles after a dump -> o_data stable and o_ready = 0 with i_valid = 1 and no count change; then i_ready=1 with sample 7 -> o_valid drops next cycle, o_count = 1, and the next dump includes 7.
REQ-035 SHALL cover gapped input: i_valid toggling 1,0,0,1,1,0,1 with samples 1,2,3,4 -> single dump of 10.
REQ-036 SHALL cover clear: i_clear after 2 samples (5, 6), then samples 1,1,1,1 -> dump = 4; i_clear with i_valid=1 and sample 9 -> sample 9 excluded.
REQ-037 SHALL cover async reset: i_rst_n pulsed low between clock edges after 3 samples, or while o_valid=1 -> outputs zero immediately; the next 4 samples 2,2,2,2 -> dump = 8.
